ddr_rw_arbiter: RTL and testbench

Round-robin arbiter that shares the single DDR read master and the single DDR write master between `NREQ` requesters. Example requesters are the instruction-driven bandwidth-test controller and future DMA/probe clients. It sits between those requesters and the `*START_REG/*ADDR_REG/*NBURST_REG/*IDLE_REG` ports of the DDR engines. It serialises transactions one at a time, and it pulses a per-requester completion when the engine returns to idle.

---
 rtl/ddr_rw_arbiter_if.sv | 42 ++++
 rtl/ddr_rw_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_ddr_rw_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_rw_arbiter_if.sv
// Request/grant bundle and DDR engine register ports for ddr_rw_arbiter.
// The master modport is the arbiter's view. The slave modport is the requesters' and engines' view.
interface ddr_rw_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*32-1:0] req_addr;
  logic [NREQ*16-1:0] req_nburst;
  logic [NREQ-1:0]    req_ack;
  logic [NREQ-1:0]    req_done;
  logic               req_err;

  logic               RSTART_REG;
  logic               WSTART_REG;
  logic [31:0]        RADDR_REG;
  logic [31:0]        WADDR_REG;
  logic [31:0]        RNBURST_REG;
  logic [31:0]        WNBURST_REG;
  logic               RIDLE_REG;
  logic               WIDLE_REG;

  logic               busy;
  logic [31:0]        last_cycles;
  logic [31:0]        xfer_cnt;

  modport master (
    input  req_valid, req_write, req_addr, req_nburst,
    output req_ack, req_done, req_err,
    output RSTART_REG, WSTART_REG, RADDR_REG, WADDR_REG, RNBURST_REG, WNBURST_REG,
    input  RIDLE_REG, WIDLE_REG,
    output busy, last_cycles, xfer_cnt
  );

  modport slave (
    output req_valid, req_write, req_addr, req_nburst,
    input  req_ack, req_done, req_err,
    input  RSTART_REG, WSTART_REG, RADDR_REG, WADDR_REG, RNBURST_REG, WNBURST_REG,
    output RIDLE_REG, WIDLE_REG,
    input  busy, last_cycles, xfer_cnt
  );
endinterface

// File: rtl/ddr_rw_arbiter.sv
// Round-robin arbiter that serialises NREQ requesters onto one DDR read engine and one DDR write engine.
// Define ARB_PERF_CNT_EN to build the transaction cycle counter (last_cycles) and the completion counter (xfer_cnt).
module ddr_rw_arbiter #(
  parameter int NREQ    = 4,
  parameter int ACK_TMO = 8
) (
  input  logic             clk,
  input  logic             rst,
  ddr_rw_arbiter_if.master bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(ACK_TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_DONE,
    S_REJECT
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic            wr_q, wr_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [31:0]     raddr_q, raddr_d;
  logic [31:0]     waddr_q, waddr_d;
  logic [15:0]     rnburst_q, rnburst_d;
  logic [15:0]     wnburst_q, wnburst_d;

  logic [NREQ-1:0] rot_valid;
  logic [NREQ-1:0] gnt_onehot;
  logic            win_found;
  logic [IW-1:0]   win_off;
  logic [IW:0]     win_sum;
  logic [IW-1:0]   win_idx;
  logic [31:0]     win_addr;
  logic [15:0]     win_nburst;
  logic            win_write;
  logic [IW-1:0]   next_ptr;
  logic            sel_idle;

  // rot_valid[k] is the request k positions above rr_ptr, so the lowest set bit is the round-robin winner
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
    logic [IW:0]   rot_sum;
    logic [IW-1:0] rot_idx;
    assign rot_sum       = {1'b0, rr_ptr_q} + (IW+1)'(gi);
    assign rot_idx       = (rot_sum >= (IW+1)'(NREQ)) ? IW'(rot_sum - (IW+1)'(NREQ)) : IW'(rot_sum);
    assign rot_valid[gi] = bus.req_valid[rot_idx];
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
    assign gnt_onehot[gi] = (gnt_q == IW'(gi));
  end

  always_comb begin
    win_found = 1'b0;
    win_off   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        win_found = 1'b1;
        win_off   = IW'(k);
      end
    end
  end

  assign win_sum    = {1'b0, rr_ptr_q} + {1'b0, win_off};
  assign win_idx    = (win_sum >= (IW+1)'(NREQ)) ? IW'(win_sum - (IW+1)'(NREQ)) : IW'(win_sum);
  assign win_addr   = bus.req_addr[win_idx*32 +: 32];
  assign win_nburst = bus.req_nburst[win_idx*16 +: 16];
  assign win_write  = bus.req_write[win_idx];
  assign next_ptr   = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + IW'(1);
  assign sel_idle   = wr_q ? bus.WIDLE_REG : bus.RIDLE_REG;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    wr_d      = wr_q;
    tmo_d     = tmo_q;
    raddr_d   = raddr_q;
    waddr_d   = waddr_q;
    rnburst_d = rnburst_q;
    wnburst_d = wnburst_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_d = win_idx;
          wr_d  = win_write;
          if (win_nburst == 16'd0) begin
            state_d = S_REJECT;
          end else begin
            // Only the engine about to be started sees its address/burst registers change
            state_d = S_ISSUE;
            if (win_write) begin
              waddr_d   = win_addr;
              wnburst_d = win_nburst;
            end else begin
              raddr_d   = win_addr;
              rnburst_d = win_nburst;
            end
          end
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (!sel_idle) begin
          state_d = S_WAIT_DONE;
        end else if (tmo_q == TW'(ACK_TMO - 1)) begin
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (sel_idle) begin
          state_d = S_DONE;
        end
      end
      S_DONE, S_REJECT: begin
        rr_ptr_d = next_ptr;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      wr_q      <= 1'b0;
      tmo_q     <= '0;
      raddr_q   <= '0;
      waddr_q   <= '0;
      rnburst_q <= '0;
      wnburst_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      wr_q      <= wr_d;
      tmo_q     <= tmo_d;
      raddr_q   <= raddr_d;
      waddr_q   <= waddr_d;
      rnburst_q <= rnburst_d;
      wnburst_q <= wnburst_d;
    end
  end

  assign bus.req_ack     = (state_q == S_ISSUE || state_q == S_REJECT) ? gnt_onehot : '0;
  assign bus.req_done    = (state_q == S_DONE  || state_q == S_REJECT) ? gnt_onehot : '0;
  assign bus.req_err     = (state_q == S_REJECT);
  assign bus.WSTART_REG  = (state_q == S_ISSUE) &&  wr_q;
  assign bus.RSTART_REG  = (state_q == S_ISSUE) && !wr_q;
  assign bus.RADDR_REG   = raddr_q;
  assign bus.WADDR_REG   = waddr_q;
  assign bus.RNBURST_REG = {16'b0, rnburst_q};
  assign bus.WNBURST_REG = {16'b0, wnburst_q};
  assign bus.busy        = (state_q != S_IDLE);

`ifdef ARB_PERF_CNT_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic [31:0] last_cycles_q, last_cycles_d;
  logic [31:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    cyc_cnt_d     = cyc_cnt_q;
    last_cycles_d = last_cycles_q;
    xfer_cnt_d    = xfer_cnt_q;
    case (state_q)
      S_ISSUE: cyc_cnt_d = '0;
      S_WAIT_ACK, S_WAIT_DONE: begin
        if (cyc_cnt_q != 32'hFFFF_FFFF) begin
          cyc_cnt_d = cyc_cnt_q + 32'd1;
        end
      end
      S_DONE: begin
        last_cycles_d = cyc_cnt_q;
        xfer_cnt_d    = xfer_cnt_q + 32'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt_q     <= '0;
      last_cycles_q <= '0;
      xfer_cnt_q    <= '0;
    end else begin
      cyc_cnt_q     <= cyc_cnt_d;
      last_cycles_q <= last_cycles_d;
      xfer_cnt_q    <= xfer_cnt_d;
    end
  end

  assign bus.last_cycles = last_cycles_q;
  assign bus.xfer_cnt    = xfer_cnt_q;
`else
  assign bus.last_cycles = '0;
  assign bus.xfer_cnt    = '0;
`endif

endmodule

// File: tb/tb_ddr_rw_arbiter.sv
// Directed bench for ddr_rw_arbiter with a behavioural read/write engine model.
// It covers reset, a single read, round-robin, reject, ack timeout and reset mid-transaction.
module tb_ddr_rw_arbiter;

  localparam int NREQ    = 4;
  localparam int ACK_TMO = 8;
`ifdef ARB_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  ddr_rw_arbiter_if #(.NREQ(NREQ)) bus ();

  ddr_rw_arbiter #(.NREQ(NREQ), .ACK_TMO(ACK_TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_start = 0;
  int n_done = 0;
  int eng_drop = 2;
  int eng_len = 50;
  bit w_ignore = 1'b0;
  int rr_exp[6] = '{0, 1, 3, 0, 1, 3};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("pass %s: 0x%08h", tag, obs);
    end
  endtask

  function automatic int oh2idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (bus.RSTART_REG || bus.WSTART_REG) n_start++;
    if (bus.req_done != '0) n_done++;
  end

  // Read engine: idle falls eng_drop cycles after the start cycle and rises eng_len cycles later
  initial begin
    bus.RIDLE_REG = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.RSTART_REG) begin
        repeat (eng_drop) @(posedge clk);
        #1 bus.RIDLE_REG = 1'b0;
        repeat (eng_len) @(posedge clk);
        #1 bus.RIDLE_REG = 1'b1;
      end
    end
  end

  initial begin
    bus.WIDLE_REG = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.WSTART_REG && !w_ignore) begin
        repeat (eng_drop) @(posedge clk);
        #1 bus.WIDLE_REG = 1'b0;
        repeat (eng_len) @(posedge clk);
        #1 bus.WIDLE_REG = 1'b1;
      end
    end
  end

  task automatic wait_ack(output int idx, output int at);
    bit got;
    got = 1'b0;
    idx = -1;
    at  = 0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (bus.req_ack != '0) begin
        got = 1'b1;
        idx = oh2idx(bus.req_ack);
        at  = cyc;
      end
    end
    check("ack_seen", 32'(got), 32'd1);
  endtask

  task automatic wait_done(output int idx, output int at, output int err);
    bit got;
    got = 1'b0;
    idx = -1;
    at  = 0;
    err = 0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (bus.req_done != '0) begin
        got = 1'b1;
        idx = oh2idx(bus.req_done);
        at  = cyc;
        err = int'(bus.req_err);
      end
    end
    check("done_seen", 32'(got), 32'd1);
    $display("txn done req%0d err=%0d at cycle %0d", idx, err, at);
  endtask

  task automatic set_req(input int i, input bit wr, input logic [31:0] addr, input logic [15:0] nb);
    bus.req_write[i]           = wr;
    bus.req_addr[i*32 +: 32]   = addr;
    bus.req_nburst[i*16 +: 16] = nb;
  endtask

  initial begin
    int idx, at, at2, derr, sc, t0;
    bus.req_valid  = '0;
    bus.req_write  = '0;
    bus.req_addr   = '0;
    bus.req_nburst = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_busy",    32'(bus.busy), 32'd0);
    check("rst_ack",     32'(bus.req_ack), 32'd0);
    check("rst_done",    32'(bus.req_done), 32'd0);
    check("rst_err",     32'(bus.req_err), 32'd0);
    check("rst_starts",  {30'd0, bus.RSTART_REG, bus.WSTART_REG}, 32'd0);
    check("rst_raddr",   bus.RADDR_REG, 32'd0);
    check("rst_wnburst", bus.WNBURST_REG, 32'd0);
    check("rst_xfer",    bus.xfer_cnt, 32'd0);
    check("rst_last",    bus.last_cycles, 32'd0);
    rst = 1'b0;

    // Single read from requester 0
    @(negedge clk);
    set_req(0, 1'b0, 32'h0000_1000, 16'h0100);
    bus.req_valid[0] = 1'b1;
    t0 = cyc;
    wait_ack(idx, at);
    check("rd_ack_vec", 32'(bus.req_ack), 32'h1);
    check("rd_ack_lat", at - t0, 32'd1);
    check("rd_rstart",  32'(bus.RSTART_REG), 32'd1);
    check("rd_wstart",  32'(bus.WSTART_REG), 32'd0);
    check("rd_raddr",   bus.RADDR_REG, 32'h0000_1000);
    check("rd_rnburst", bus.RNBURST_REG, 32'h0000_0100);
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    check("rd_start_pulse", 32'(bus.RSTART_REG), 32'd0);
    wait_done(idx, at2, derr);
    check("rd_done_idx", idx, 32'd0);
    check("rd_done_err", derr, 32'd0);
    check("rd_done_lat", at2 - at, 32'd53);
    @(negedge clk);
    check("rd_done_pulse", 32'(bus.req_done), 32'd0);
    check("rd_busy_after", 32'(bus.busy), 32'd0);
    check("rd_last_cycles", bus.last_cycles, PERF ? 32'd52 : 32'd0);
    check("rd_xfer", bus.xfer_cnt, PERF ? 32'd1 : 32'd0);

    // Round-robin among 0, 1 and 3 from a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    eng_drop = 1;
    eng_len  = 3;
    set_req(0, 1'b0, 32'h0000_0100, 16'h0010);
    set_req(1, 1'b1, 32'h0000_0200, 16'h0020);
    set_req(3, 1'b1, 32'h0000_0400, 16'h0040);
    bus.req_valid = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      wait_ack(idx, at);
      check("rr_grant",  idx, rr_exp[k]);
      check("rr_wstart", 32'(bus.WSTART_REG), (rr_exp[k] != 0) ? 32'd1 : 32'd0);
      check("rr_rstart", 32'(bus.RSTART_REG), (rr_exp[k] == 0) ? 32'd1 : 32'd0);
      wait_done(idx, at2, derr);
      check("rr_done_idx", idx, rr_exp[k]);
    end
    bus.req_valid = '0;
    @(negedge clk);
    check("rr_xfer", bus.xfer_cnt, PERF ? 32'd6 : 32'd0);

    // Reject: requester 2 with a zero burst count
    sc = n_start;
    set_req(2, 1'b1, 32'h9999_0000, 16'h0000);
    bus.req_valid[2] = 1'b1;
    wait_ack(idx, at);
    check("rej_ack",  32'(bus.req_ack), 32'h4);
    check("rej_done", 32'(bus.req_done), 32'h4);
    check("rej_err",  32'(bus.req_err), 32'd1);
    bus.req_valid[2] = 1'b0;
    repeat (2) @(negedge clk);
    check("rej_no_start",  n_start, sc);
    check("rej_raddr_hold", bus.RADDR_REG, 32'h0000_0100);
    check("rej_rnb_hold",   bus.RNBURST_REG, 32'h0000_0010);
    check("rej_waddr_hold", bus.WADDR_REG, 32'h0000_0400);
    check("rej_xfer",       bus.xfer_cnt, PERF ? 32'd6 : 32'd0);

    set_req(3, 1'b0, 32'h0000_3000, 16'h0030);
    set_req(1, 1'b1, 32'h0000_7000, 16'h0070);
    bus.req_valid = 4'b1010;
    wait_ack(idx, at);
    check("rej_next_grant", idx, 32'd3);
    check("rej_next_raddr", bus.RADDR_REG, 32'h0000_3000);
    bus.req_valid[3] = 1'b0;
    wait_done(idx, at2, derr);
    wait_ack(idx, at);
    check("wrap_grant", idx, 32'd1);
    check("wrap_waddr", bus.WADDR_REG, 32'h0000_7000);
    check("wrap_raddr_hold", bus.RADDR_REG, 32'h0000_3000);
    bus.req_valid[1] = 1'b0;
    wait_done(idx, at2, derr);

    // Ack timeout: write engine never leaves idle
    w_ignore = 1'b1;
    set_req(1, 1'b1, 32'h0000_8000, 16'h0008);
    bus.req_valid = 4'b0010;
    wait_ack(idx, at);
    check("tmo_grant",  idx, 32'd1);
    check("tmo_wstart", 32'(bus.WSTART_REG), 32'd1);
    bus.req_valid = '0;
    wait_done(idx, at2, derr);
    check("tmo_done_idx", idx, 32'd1);
    check("tmo_err",      derr, 32'd0);
    check("tmo_lat",      at2 - at, 32'd9);
    @(negedge clk);
    check("tmo_last_cycles", bus.last_cycles, PERF ? 32'd8 : 32'd0);
    check("tmo_xfer",        bus.xfer_cnt, PERF ? 32'd9 : 32'd0);
    w_ignore = 1'b0;

    // Reset while waiting for the read engine to finish
    eng_drop = 2;
    eng_len  = 50;
    set_req(2, 1'b0, 32'h0000_A000, 16'h0050);
    bus.req_valid = 4'b0100;
    wait_ack(idx, at);
    check("mid_grant", idx, 32'd2);
    bus.req_valid = '0;
    repeat (6) @(negedge clk);
    check("mid_busy", 32'(bus.busy), 32'd1);
    sc = n_done;
    rst = 1'b1;
    #1;
    check("mid_rst_busy",    32'(bus.busy), 32'd0);
    check("mid_rst_raddr",   bus.RADDR_REG, 32'd0);
    check("mid_rst_rnburst", bus.RNBURST_REG, 32'd0);
    check("mid_rst_waddr",   bus.WADDR_REG, 32'd0);
    check("mid_rst_ackdone", {bus.req_ack, bus.req_done}, 32'd0);
    check("mid_rst_xfer",    bus.xfer_cnt, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("mid_no_done", n_done, sc);

    eng_drop = 1;
    eng_len  = 3;
    set_req(1, 1'b0, 32'h0000_5000, 16'h0004);
    set_req(2, 1'b0, 32'h0000_6000, 16'h0006);
    bus.req_valid = 4'b0110;
    wait_ack(idx, at);
    check("post_rst_grant", idx, 32'd1);
    check("post_rst_raddr", bus.RADDR_REG, 32'h0000_5000);
    bus.req_valid = '0;
    wait_done(idx, at2, derr);
    check("post_rst_done", idx, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
